// File: rtl/fp_vec_checker.sv
// rtl/fp_vec_checker.sv - walks an FP-add test vector table in VEDA memory and scores the adder
// Each vector is three words (A, B, expected sum); five cycles per vector.
module fp_vec_checker #(
   parameter int NUM_VEC   = 4,
   parameter int BASE_ADDR = 0,
   parameter int ADDR_W    = 5,
   parameter int CNT_W     = 8,
   parameter int ZERO_EQ   = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              mem_mode,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       add_a,
   output logic [31:0]       add_b,
   input  logic [31:0]       add_result,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [CNT_W-1:0]  first_fail,
   output logic              led
);

   typedef enum logic [2:0] {IDLE, RA, RB, RE, WT, CMP, DONE} state_t;

   localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
   localparam logic [CNT_W-1:0]  LAST = CNT_W'(NUM_VEC - 1);
   localparam logic [CNT_W-1:0]  NONE = {CNT_W{1'b1}};

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  idx;
   logic [31:0]       exp_word;
   logic              match;

   assign mem_mode = 1'b1;
   assign mem_we   = 1'b0;

   // +0 and -0 differ only in the sign bit
   always_comb begin
      match = (add_result == exp_word);
      if (ZERO_EQ != 0 && add_result[30:0] == 31'd0 && exp_word[30:0] == 31'd0)
         match = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         ptr        <= BASE;
         idx        <= '0;
         add_a      <= '0;
         add_b      <= '0;
         exp_word   <= '0;
         mem_addr   <= BASE;
         pass_cnt   <= '0;
         fail_cnt   <= '0;
         first_fail <= NONE;
         busy       <= 1'b0;
         done       <= 1'b0;
         led        <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  pass_cnt   <= '0;
                  fail_cnt   <= '0;
                  first_fail <= NONE;
                  ptr        <= BASE;
                  idx        <= '0;
                  mem_addr   <= BASE;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  led        <= 1'b0;
                  state      <= RA;
               end
            end
            RA: begin
               mem_addr <= ptr + ADDR_W'(1);
               state    <= RB;
            end
            RB: begin
               add_a    <= mem_rdata;
               mem_addr <= ptr + ADDR_W'(2);
               state    <= RE;
            end
            RE: begin
               add_b <= mem_rdata;
               state <= WT;
            end
            WT: begin
               exp_word <= mem_rdata;
               state    <= CMP;
            end
            CMP: begin
               if (match) begin
                  pass_cnt <= pass_cnt + CNT_W'(1);
               end else begin
                  fail_cnt <= fail_cnt + CNT_W'(1);
                  if (first_fail == NONE)
                     first_fail <= idx;
               end
               if (idx == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  led   <= match && (fail_cnt == '0);
                  state <= DONE;
               end else begin
                  ptr      <= ptr + ADDR_W'(3);
                  mem_addr <= ptr + ADDR_W'(3);
                  idx      <= idx + CNT_W'(1);
                  state    <= RA;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fp_vec_checker.md
Name: fp_vec_checker

Overview:
- Sequencer that sits directly upstream of the combinational FP adder and replaces the fixed-operand top-level check.
- Walks a table of test vectors in VEDA memory. Each vector is three 32-bit words at consecutive addresses: operand A, operand B, expected sum.
- Drives the adder operands, compares the adder result against the expected word, and reports pass/fail counts and a summary LED.

Parameters:
- NUM_VEC, 4, number of vectors in the table; legal range 1 to 2^CNT_W-1.
- BASE_ADDR, 0, VEDA address of vector 0, word A.
- ADDR_W, 5, width of the memory address.
- CNT_W, 8, width of the pass/fail counters and of the vector index.
- ZERO_EQ, 0, when 1, 32'h00000000 and 32'h80000000 compare equal; otherwise comparison is exact bitwise.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; reset is asynchronous and active-low.
- start  input  1  one-cycle pulse that begins a run.
- mem_mode  output  1  VEDA mode; tied to 1 (read).
- mem_we  output  1  VEDA write_enable; tied to 0.
- mem_addr  output  ADDR_W  VEDA read address.
- mem_rdata  input  32  VEDA data_out; valid 1 cycle after mem_addr.
- add_a  output  32  FP adder operand A (registered).
- add_b  output  32  FP adder operand B (registered).
- add_result  input  32  combinational FP adder sum of add_a and add_b.
- busy  output  1  high from the cycle after start until DONE.
- done  output  1  high in DONE; held until the next start.
- pass_cnt  output  CNT_W  vectors matched.
- fail_cnt  output  CNT_W  vectors mismatched.
- first_fail  output  CNT_W  index of the first mismatching vector; all-ones if none.
- led  output  1  equals done AND (fail_cnt==0).

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; ptr=BASE_ADDR; idx=0.
  - add_a=add_b=0; exp=0; mem_addr=BASE_ADDR.
  - pass_cnt=fail_cnt=0; first_fail=all-ones.
  - busy=done=led=0.
- Reset mid-run aborts immediately; no partial results are retained.
- States and transitions:
  - IDLE: on start, clear counters and set first_fail=all-ones, ptr=BASE_ADDR, idx=0, go to RA. Otherwise hold.
  - RA: mem_addr=ptr; go to RB.
  - RB: mem_addr=ptr+1; add_a<=mem_rdata; go to RE.
  - RE: mem_addr=ptr+2; add_b<=mem_rdata; go to WT.
  - WT: exp<=mem_rdata; go to CMP. Adder settles during this cycle.
  - CMP: match = (add_result==exp), or both values in {0x00000000, 0x80000000} when ZERO_EQ=1.
    - On match: pass_cnt++.
    - On mismatch: fail_cnt++; if first_fail is all-ones, first_fail<=idx.
    - If idx==NUM_VEC-1, go to DONE. Otherwise ptr+=3, idx++, go to RA.
  - DONE: done=1; counters hold. start restarts exactly as from IDLE, with done dropping the next cycle.
- Timing:
  - Each vector takes 5 cycles, so a full run is 5*NUM_VEC cycles from the first RA to DONE entry.
  - mem_addr is registered, so the address for state S is presented during S.
- start is ignored while busy.
- ptr arithmetic wraps modulo 2^ADDR_W; address overflow is the table author's responsibility.
- busy=1 exactly in states RA through CMP.
- No write is ever issued to VEDA.

Test Plan:
- Single match (NUM_VEC=1, BASE_ADDR=2): mem[2]=0x42BA8000 (93.25), mem[3]=0x414D0000 (12.8125), mem[4]=0x42D42000 (106.0625), bench uses the real fp_adder, pulse start → done after 5 cycles, pass_cnt=1, fail_cnt=0, first_fail=0xFF, led=1.
- Mismatch (NUM_VEC=3): vector 1 expected corrupted to 0x42D42001 → pass_cnt=2, fail_cnt=1, first_fail=1, led=0.
- Signed zero: A=0x3F800000, B=0xBF800000, expected=0x80000000 → fail with ZERO_EQ=0; pass with ZERO_EQ=1.
- Reset mid-run: assert reset in the RE state of vector 2 → all outputs zero / all-ones immediately; a new start reruns from vector 0 with fresh counts.
- start while busy: pulse start at cycle 3 of a run → no restart, final counts unchanged. start in DONE → full rerun, done low for 5*NUM_VEC cycles.
- Address sequence: NUM_VEC=2, BASE_ADDR=0 → mem_addr sequence 0,1,2,x,x,3,4,5; mem_we=0 and mem_mode=1 in every cycle.
